// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: {Cout,S} = A + B + Cin, one full-adder cell, LSB first, WIDTH RUN cycles per add.
// Optional signed-overflow output ovf is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             w_load;
    logic             w_run;
    logic             w_last;
    logic             w_fa_sum;
    logic             w_fa_cy;
`ifdef SERIAL_ADDER_OVF_EN
    logic             r_ovf;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (r_cnt == LAST) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                // Back-to-back accept: a start seen in DONE goes straight to RUN.
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_run  = (r_state == RUN);
    assign w_last = w_run && (r_cnt == LAST);

    assign w_fa_sum = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_fa_cy  = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));

    // S/Cout are deliberately not cleared on load; they are overwritten bit by bit in RUN.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else if (w_load) begin
            r_a     <= A;
            r_b     <= B;
            r_carry <= Cin;
            r_cnt   <= '0;
        end else if (w_run) begin
            r_a     <= {1'b0, r_a[WIDTH-1:1]};
            r_b     <= {1'b0, r_b[WIDTH-1:1]};
            r_sum   <= {w_fa_sum, r_sum[WIDTH-1:1]};
            r_carry <= w_fa_cy;
            if (w_last) begin
                r_cout <= w_fa_cy;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // On the MSB cycle r_carry is the carry into the MSB, w_fa_cy the carry out.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= r_carry ^ w_fa_cy;
        end
    end

    assign ovf = r_ovf;
`endif

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign S    = r_sum;
    assign Cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8): driver pushes expected results, a
// negedge monitor pops and compares on every done pulse. Define SERIAL_ADDER_OVF_EN to check ovf.
module tb_serial_adder_ctrl;

    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    logic         clk;
    logic         resetn;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         busy;
    logic         done;
    logic [W-1:0] S;
    logic         Cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
`ifdef SERIAL_ADDER_OVF_EN
        .ovf    (ovf),
`endif
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .A      (A),
        .B      (B),
        .Cin    (Cin),
        .busy   (busy),
        .done   (done),
        .S      (S),
        .Cout   (Cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        exp_t        e;
        logic [W:0]  full;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        e.s  = full[W-1:0];
        e.c  = full[W];
        e.o  = (a[W-1] == b[W-1]) && (e.s[W-1] != a[W-1]);
        return e;
    endfunction

    function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic o);
        exp_t e;
        e.s = s;
        e.c = c;
        e.o = o;
        return e;
    endfunction

    // Monitor: compares every done pulse against the head of the scoreboard.
    always @(negedge clk) begin
        if (resetn) begin
            chk("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("S", {24'd0, S}, {24'd0, e.s});
                    chk("Cout", {31'd0, Cout}, {31'd0, e.c});
`ifdef SERIAL_ADDER_OVF_EN
                    chk("ovf", {31'd0, ovf}, {31'd0, e.o});
`endif
                end
            end
        end
    end

    // Waits (bounded) for a done pulse; returns at the negedge where done is seen.
    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (!done && k < 30) begin
            @(negedge clk);
            k++;
        end
        if (!done) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Issues one add; 'now' means drive at the current negedge (DUT is in DONE or IDLE).
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input exp_t e, input bit now);
        if (!now) @(negedge clk);
        A = a; B = b; Cin = ci; start = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        wait_done("send");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, t2, gap;
        exp_t e;
        logic [W-1:0] ra, rb;
        logic rc;
        bit now;

        resetn = 1'b0; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
        #2;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_S", {24'd0, S}, 32'd0);
        chk("reset_Cout", {31'd0, Cout}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("reset_ovf", {31'd0, ovf}, 32'd0);
`endif
        @(negedge clk); @(negedge clk);
        resetn = 1'b1;

        // Latency profile: busy for 8 cycles after accept, done on the 9th.
        @(negedge clk);
        A = 8'h0F; B = 8'h01; Cin = 1'b0; start = 1'b1;
        sb.push_back(mk(8'h10, 1'b0, 1'b0));
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            chk($sformatf("lat_busy_c%0d", k), {31'd0, busy}, {31'd0, (k <= 8) ? 1'b1 : 1'b0});
            chk($sformatf("lat_done_c%0d", k), {31'd0, done}, {31'd0, (k == 9) ? 1'b1 : 1'b0});
        end

        send(8'hFF, 8'h01, 1'b0, mk(8'h00, 1'b1, 1'b0), 1'b0);
        send(8'hFF, 8'hFF, 1'b1, mk(8'hFF, 1'b1, 1'b0), 1'b0);
        send(8'h7F, 8'h01, 1'b0, mk(8'h80, 1'b0, 1'b1), 1'b0);
        send(8'h80, 8'h80, 1'b0, mk(8'h00, 1'b1, 1'b1), 1'b0);
        send(8'h55, 8'hAA, 1'b1, mk(8'h00, 1'b1, 1'b0), 1'b0);
        send(8'hA5, 8'h5A, 1'b0, mk(8'hFF, 1'b0, 1'b0), 1'b1);

        // start held high with changing operands during RUN; second add accepted from DONE.
        @(negedge clk);
        A = 8'h12; B = 8'h34; Cin = 1'b0; start = 1'b1;
        sb.push_back(mk(8'h46, 1'b0, 1'b0));
        t1 = -1;
        for (int k = 0; k < 30 && t1 < 0; k++) begin
            @(negedge clk);
            if (done) begin
                t1 = cyc;
                A = 8'h21; B = 8'h43; Cin = 1'b1;
                sb.push_back(mk(8'h65, 1'b0, 1'b0));
            end else begin
                A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
            end
        end
        if (t1 < 0) chk("b2b_first_timeout", 32'd0, 32'd1);
        @(negedge clk);
        start = 1'b0;
        wait_done("b2b_second");
        t2 = cyc;
        chk("b2b_done_spacing", 32'(t2 - t1), 32'd9);

        // Reset in the middle of an operation: outputs clear at once, no done.
        @(negedge clk);
        A = 8'h11; B = 8'h22; Cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_S", {24'd0, S}, 32'd0);
        chk("abort_Cout", {31'd0, Cout}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("abort_ovf", {31'd0, ovf}, 32'd0);
`endif
        repeat (3) @(negedge clk);
        chk("abort_hold_done", {31'd0, done}, 32'd0);
        resetn = 1'b1;
        repeat (12) @(negedge clk);
        send(8'h03, 8'h04, 1'b0, mk(8'h07, 1'b0, 1'b0), 1'b0);

        // Random adds with random gaps; gap 0 accepts straight from DONE.
        for (int n = 0; n < 1000; n++) begin
            gap = $urandom_range(0, 3);
            now = (gap == 0);
            if (gap > 1) repeat (gap - 1) @(negedge clk);
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            e = model(ra, rb, rc);
            send(ra, rb, rc, e, now);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
